trap_controller: RTL
====================

# trap_controller

Sequences machine-mode trap entry and `mret` return for the CSR register file. It collects exception requests from the IF, ID and EX stages and the `mret` request from EX, and picks the oldest one. It then drives the CSR file's exception-code/mtval/epc inputs for exactly one cycle, flushes the pipeline and redirects the PC to mtvec or mepc. It sits between the pipeline control logic and the CSR file.

## Interface
- `XLEN`, 32, data/address width
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `if_exc_valid`, `id_exc_valid`, `ex_exc_valid`  in  1 each  exception request from that stage
- `if_exc_cause`, `id_exc_cause`, `ex_exc_cause`  in  5 each  mcause code (0..30)
- `if_exc_pc`, `id_exc_pc`, `ex_exc_pc`  in  XLEN each  faulting instruction PC
- `if_exc_tval`, `id_exc_tval`, `ex_exc_tval`  in  XLEN each  trap value
- `mret_req`  in  1  mret executing in EX
- `csr_mtvec`  in  XLEN  current mtvec, write-forwarded by the CSR file
- `csr_mepc`  in  XLEN  current mepc, write-forwarded
- `exception_code`  out  6  to CSR file: bit5 = trap, `6'b011111` = mret, else 0
- `exception_mtval`  out  XLEN  to CSR file
- `trap_epc`  out  XLEN  epc; the pipeline muxes it onto the CSR write data when `exception_code[5]` is set
- `flush`  out  1  kill all instructions in IF/ID/EX
- `redirect_valid`  out  1  PC load strobe
- `redirect_pc`  out  XLEN  new PC
- `busy`  out  1  FSM not in IDLE
- `trap_count`  out  16  number of trap entries, saturating

## Operation
- FSM states: IDLE, SAVE, MRET, REDIRECT.
- Arbitration in IDLE, fixed priority: `ex_exc_valid` > `mret_req` > `id_exc_valid` > `if_exc_valid`.
  - An EX exception beats `mret`: the mret itself faulted.
  - ID and IF requests are younger than an mret in EX, so mret beats them.
- Accept an exception in IDLE:
  - Latch the winning cause, pc and tval; go to SAVE.
  - A cause of 31 is remapped to 2 (illegal instruction), because code 31 is reserved for mret encoding.
- Accept mret in IDLE: go to MRET.
- SAVE, one cycle:
  - `exception_code = {1'b1, cause}`, `exception_mtval = tval`, `trap_epc = pc`.
  - Increment `trap_count`; it saturates at 16'hFFFF.
  - Go to REDIRECT with target = `{csr_mtvec[XLEN-1:2], 2'b00}`. Only direct mode is supported; mtvec[1:0] are ignored.
- MRET, one cycle: `exception_code = 6'b011111`; go to REDIRECT with target = `{csr_mepc[XLEN-1:1], 1'b0}`.
- REDIRECT, one cycle:
  - `redirect_valid = 1`, `redirect_pc` = target.
  - The target is sampled from `csr_mtvec`/`csr_mepc` in this cycle.
  - Go to IDLE.
- `flush` = request accepted this cycle in IDLE (combinational) OR state != IDLE.
- All requests arriving in SAVE, MRET or REDIRECT are ignored; they are wrong-path.
- Outside SAVE and MRET: `exception_code = 0`, `exception_mtval = 0`, `trap_epc = 0`.
- `redirect_pc = 0` whenever `redirect_valid = 0`.

## Timing
- Reset, asynchronous: state IDLE, `trap_count = 0`, latched cause/pc/tval = 0.
  - All outputs are 0 during reset and in IDLE with no request.
- Exception accepted at cycle N:
  - `flush` high at N, N+1, N+2.
  - SAVE at N+1.
  - `redirect_valid` at N+2.
  - Earliest next acceptance at N+3.
- mret accepted at N: MRET at N+1, redirect to mepc at N+2. Same latency as an exception.
- Back-to-back: a request held high through N+3 is accepted at N+3.
- CSR write to mtvec/mepc in the SAVE/MRET cycle: REDIRECT uses the updated value, via CSR forwarding and the registered update.
- Reset asserted mid-sequence: return to IDLE immediately.
  - No redirect is issued.
  - `trap_count` clears.

## Test plan
- ID illegal instruction:
  - Stimulus: `id_exc_valid=1`, cause 2, pc 0x100, tval 0xDEAD; mtvec = 0x80.
  - Response: flush N..N+2; SAVE gives `exception_code = 6'b100010`, `trap_epc = 0x100`, `exception_mtval = 0xDEAD`; N+2 gives `redirect_pc = 0x80`; `trap_count = 1`.
- Simultaneous requests:
  - Stimulus: `if_exc_valid`, `id_exc_valid`, `ex_exc_valid` (cause 11, pc 0x200) and `mret_req` all high.
  - Response: EX wins; code `6'b101011`; `trap_epc = 0x200`; the other requests are dropped.
- mret vs ID exception:
  - Stimulus: `mret_req` and `id_exc_valid` together; mepc = 0x204.
  - Response: MRET gives code `6'b011111`; then `redirect_pc = 0x204`; `trap_count` unchanged.
- Alignment and cause remap:
  - Stimulus: mtvec = 0x83; ex cause 31.
  - Response: `redirect_pc = 0x80`; code `6'b100010`.
- Reset mid-trap and counter saturation:
  - Stimulus: `rst_n` low during SAVE; separately, 65 536 traps.
  - Response: reset gives IDLE, no `redirect_valid`, all outputs 0; the traps leave `trap_count = 16'hFFFF`.

Source files
------------

// File: rtl/trap_controller.sv
// Machine-mode trap sequencer: arbitrates IF/ID/EX exceptions and mret, drives the CSR
// file's trap inputs for one cycle, flushes the pipeline and redirects the PC.
module trap_controller #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_exc_valid,
  input  logic            id_exc_valid,
  input  logic            ex_exc_valid,
  input  logic [4:0]      if_exc_cause,
  input  logic [4:0]      id_exc_cause,
  input  logic [4:0]      ex_exc_cause,
  input  logic [XLEN-1:0] if_exc_pc,
  input  logic [XLEN-1:0] id_exc_pc,
  input  logic [XLEN-1:0] ex_exc_pc,
  input  logic [XLEN-1:0] if_exc_tval,
  input  logic [XLEN-1:0] id_exc_tval,
  input  logic [XLEN-1:0] ex_exc_tval,
  input  logic            mret_req,
  input  logic [XLEN-1:0] csr_mtvec,
  input  logic [XLEN-1:0] csr_mepc,
  output logic [5:0]      exception_code,
  output logic [XLEN-1:0] exception_mtval,
  output logic [XLEN-1:0] trap_epc,
  output logic            flush,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            busy,
  output logic [15:0]     trap_count
);

  typedef enum logic [1:0] {IDLE, SAVE, MRET, REDIRECT} state_t;

  state_t          state_q, state_d;
  logic [4:0]      cause_q;
  logic [XLEN-1:0] pc_q, tval_q;
  logic            ret_q;

  logic            take_exc, take_mret;
  logic [4:0]      sel_cause, latch_cause;
  logic [XLEN-1:0] sel_pc, sel_tval;

  // Only direct-mode mtvec and halfword-aligned mepc are used as targets.
  logic unused_bits;
  assign unused_bits = ^{csr_mtvec[1:0], csr_mepc[0]};

  // An EX fault beats mret (the mret itself faulted); mret beats the younger ID/IF.
  always_comb begin
    take_exc  = 1'b0;
    take_mret = 1'b0;
    sel_cause = '0;
    sel_pc    = '0;
    sel_tval  = '0;
    if (state_q == IDLE && rst_n) begin
      if (ex_exc_valid) begin
        take_exc  = 1'b1;
        sel_cause = ex_exc_cause;
        sel_pc    = ex_exc_pc;
        sel_tval  = ex_exc_tval;
      end else if (mret_req) begin
        take_mret = 1'b1;
      end else if (id_exc_valid) begin
        take_exc  = 1'b1;
        sel_cause = id_exc_cause;
        sel_pc    = id_exc_pc;
        sel_tval  = id_exc_tval;
      end else if (if_exc_valid) begin
        take_exc  = 1'b1;
        sel_cause = if_exc_cause;
        sel_pc    = if_exc_pc;
        sel_tval  = if_exc_tval;
      end
    end
  end

  // Code 31 is reserved for the mret encoding, so it is reported as illegal instruction.
  assign latch_cause = (sel_cause == 5'd31) ? 5'd2 : sel_cause;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cause_q <= '0;
      pc_q    <= '0;
      tval_q  <= '0;
      ret_q   <= 1'b0;
    end else if (take_exc) begin
      cause_q <= latch_cause;
      pc_q    <= sel_pc;
      tval_q  <= sel_tval;
      ret_q   <= 1'b0;
    end else if (take_mret) begin
      ret_q   <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trap_count <= '0;
    end else if (state_q == SAVE && trap_count != 16'hFFFF) begin
      trap_count <= trap_count + 16'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (take_exc) begin
          state_d = SAVE;
        end else if (take_mret) begin
          state_d = MRET;
        end
      end
      SAVE:     state_d = REDIRECT;
      MRET:     state_d = REDIRECT;
      REDIRECT: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // The redirect target is read from the CSR inputs in the REDIRECT cycle itself so a
  // CSR write during SAVE/MRET is honoured.
  always_comb begin
    exception_code  = '0;
    exception_mtval = '0;
    trap_epc        = '0;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    unique case (state_q)
      SAVE: begin
        exception_code  = {1'b1, cause_q};
        exception_mtval = tval_q;
        trap_epc        = pc_q;
      end
      MRET: begin
        exception_code = 6'b011111;
      end
      REDIRECT: begin
        redirect_valid = 1'b1;
        redirect_pc    = ret_q ? {csr_mepc[XLEN-1:1], 1'b0} : {csr_mtvec[XLEN-1:2], 2'b00};
      end
      default: begin
      end
    endcase
    busy  = (state_q != IDLE);
    flush = take_exc | take_mret | (state_q != IDLE);
  end

endmodule
